mv_mem_arbiter: RTL and testbench

- Shares one single-port motion-vector memory (9-bit entries; bit 8 set = NULL vector) between two requesters.
- Typical requesters: the median-filter neighbour fetch and the filtered-vector write-back/ME writer.
- Converts 1-based (row, col) block coordinates into a linear index. Out-of-frame reads are answered with the NULL vector without touching memory.
- Provides round-robin arbitration with a per-requester lock, so a 3x3 neighbourhood fetch can keep priority.

---
 rtl/mv_mem_pkg.sv | 15 +
 rtl/mv_index_calc.sv | 28 ++
 rtl/mv_mem_arbiter.sv | 135 +++++++++++++
 tb/tb_mv_mem_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mv_mem_pkg.sv
// Shared constants and FSM encoding for the motion-vector memory arbiter.
// NULL_BIT marks the flag bit that tags an entry as a NULL vector.
package mv_mem_pkg;

    localparam int DW = 9;
    localparam int AW = 16;
    localparam int NULL_BIT = DW - 1;
    localparam logic [DW-1:0] NULL_MV = 9'h100;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } arb_state_t;

endpackage

// File: rtl/mv_index_calc.sv
// Maps 1-based (row, col) block coordinates to a linear memory index.
// Also reports whether the coordinates fall inside the frame.
module mv_index_calc
    import mv_mem_pkg::*;
(
    input  logic [7:0]    row,
    input  logic [7:0]    col,
    input  logic [7:0]    width,
    input  logic [7:0]    height,
    output logic [AW-1:0] index,
    output logic          in_frame
);

    logic [7:0]    row_m1;
    logic [7:0]    col_m1;
    logic [AW-1:0] row_base;

    assign row_m1 = row - 8'd1;
    assign col_m1 = col - 8'd1;

    // 255*255 + 254 fits in 16 bits, so the widened product never wraps
    assign row_base = AW'(row_m1) * AW'(width);
    assign index    = row_base + AW'(col_m1);

    assign in_frame = (row != 8'd0) && (col != 8'd0) &&
                      (row <= height) && (col <= width);

endmodule

// File: rtl/mv_mem_arbiter.sv
// Round-robin arbiter with burst lock sharing one single-port MV memory
// between two requesters; out-of-frame reads return NULL_MV without a memory access.
module mv_mem_arbiter
    import mv_mem_pkg::*;
(
    input  logic                 CLK,
    input  logic                 reset,
    input  logic [7:0]           width,
    input  logic [7:0]           height,
    input  logic [1:0]           req,
    input  logic [1:0]           lock,
    input  logic [1:0]           we,
    input  logic [1:0][7:0]      row,
    input  logic [1:0][7:0]      col,
    input  logic [1:0][DW-1:0]   wdata,
    output logic [1:0]           gnt,
    output logic [1:0]           rvalid,
    output logic [DW-1:0]        rdata,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [AW-1:0]        mem_addr,
    output logic [DW-1:0]        mem_wdata,
    input  logic [DW-1:0]        mem_rdata
);

    arb_state_t    state_reg, state_next;
    logic [1:0]    gnt_reg, gnt_next;
    logic [1:0]    rvalid_reg, rvalid_next;
    logic          rnull_reg, rnull_next;
    logic [DW-1:0] rdata_hold_reg;
    logic          mem_en_reg, mem_en_next;
    logic          mem_we_reg, mem_we_next;
    logic [AW-1:0] mem_addr_reg, mem_addr_next;
    logic [DW-1:0] mem_wdata_reg, mem_wdata_next;
    logic          pend_valid_reg, pend_valid_next;
    logic          pend_owner_reg, pend_owner_next;
    logic          pend_null_reg, pend_null_next;
    logic          prio_reg, prio_next;

    logic [1:0]    elig;
    logic          any_elig;
    logic          win;
    logic [AW-1:0] win_index;
    logic          win_in_frame;

    // A requester granted last cycle is masked so its held req is not re-served
    always_comb begin
        elig     = req & ~gnt_reg;
        any_elig = |elig;
        win      = (&elig) ? prio_reg : elig[1];
    end

    mv_index_calc u_index_calc (
        .row      (row[win]),
        .col      (col[win]),
        .width    (width),
        .height   (height),
        .index    (win_index),
        .in_frame (win_in_frame)
    );

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_req
            assign gnt_next[gi]    = any_elig && (win == 1'(gi));
            assign rvalid_next[gi] = (state_reg == ST_ISSUE) && pend_valid_reg &&
                                     (pend_owner_reg == 1'(gi));
        end
    endgenerate

    always_comb begin
        state_next      = any_elig ? ST_ISSUE : ST_IDLE;
        mem_en_next     = 1'b0;
        mem_we_next     = 1'b0;
        mem_addr_next   = mem_addr_reg;
        mem_wdata_next  = mem_wdata_reg;
        pend_valid_next = 1'b0;
        pend_owner_next = pend_owner_reg;
        pend_null_next  = pend_null_reg;
        prio_next       = prio_reg;
        rnull_next      = pend_null_reg;
        if (any_elig) begin
            mem_en_next     = win_in_frame;
            mem_we_next     = win_in_frame & we[win];
            mem_addr_next   = win_index;
            mem_wdata_next  = wdata[win];
            pend_valid_next = ~we[win];
            pend_owner_next = win;
            pend_null_next  = ~win_in_frame;
            // A locked winner keeps the top slot; otherwise it drops to the bottom
            prio_next       = lock[win] ? win : ~win;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            gnt_reg        <= 2'b00;
            rvalid_reg     <= 2'b00;
            rnull_reg      <= 1'b0;
            rdata_hold_reg <= '0;
            mem_en_reg     <= 1'b0;
            mem_we_reg     <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            pend_valid_reg <= 1'b0;
            pend_owner_reg <= 1'b0;
            pend_null_reg  <= 1'b0;
            prio_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            gnt_reg        <= gnt_next;
            rvalid_reg     <= rvalid_next;
            rnull_reg      <= rnull_next;
            rdata_hold_reg <= rdata;
            mem_en_reg     <= mem_en_next;
            mem_we_reg     <= mem_we_next;
            mem_addr_reg   <= mem_addr_next;
            mem_wdata_reg  <= mem_wdata_next;
            pend_valid_reg <= pend_valid_next;
            pend_owner_reg <= pend_owner_next;
            pend_null_reg  <= pend_null_next;
            prio_reg       <= prio_next;
        end
    end

    // Memory data arrives in the rvalid cycle itself, so it is passed straight through
    assign rdata     = (|rvalid_reg) ? (rnull_reg ? NULL_MV : mem_rdata) : rdata_hold_reg;
    assign gnt       = gnt_reg;
    assign rvalid    = rvalid_reg;
    assign mem_en    = mem_en_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;

endmodule

// File: tb/tb_mv_mem_arbiter.sv
// Scoreboard bench for mv_mem_arbiter: stimulus queues expected grants/read
// responses, a negedge monitor pops and compares them as the DUT presents them.
module tb_mv_mem_arbiter;

    logic             CLK = 1'b0;
    logic             reset = 1'b1;
    logic [7:0]       width = 8'd4;
    logic [7:0]       height = 8'd3;
    logic [1:0]       req = 2'b00;
    logic [1:0]       lock = 2'b00;
    logic [1:0]       we = 2'b00;
    logic [1:0][7:0]  row = '0;
    logic [1:0][7:0]  col = '0;
    logic [1:0][8:0]  wdata = '0;
    logic [1:0]       gnt;
    logic [1:0]       rvalid;
    logic [8:0]       rdata;
    logic             mem_en;
    logic             mem_we;
    logic [15:0]      mem_addr;
    logic [8:0]       mem_wdata;
    logic [8:0]       mem_rdata = 9'h000;

    mv_mem_arbiter dut (
        .CLK       (CLK),
        .reset     (reset),
        .width     (width),
        .height    (height),
        .req       (req),
        .lock      (lock),
        .we        (we),
        .row       (row),
        .col       (col),
        .wdata     (wdata),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 CLK = ~CLK;

    int   cyc = 0;
    logic reset_q = 1'b1;
    always @(posedge CLK) begin
        cyc     <= cyc + 1;
        reset_q <= reset;
    end

    // Memory stand-in: read data is a fixed pattern of the address
    always @(posedge CLK)
        if (mem_en && !mem_we) mem_rdata <= {1'b0, mem_addr[7:0] ^ 8'h3C};

    typedef struct packed {
        logic        id;
        logic        en;
        logic        wr;
        logic        lat;
        logic [15:0] addr;
        logic [8:0]  wdata;
    } gnt_exp_t;

    typedef struct packed {
        logic       id;
        logic [8:0] data;
    } rv_exp_t;

    gnt_exp_t   gq[$];
    rv_exp_t    rq[$];
    int         req_cycle[2];
    int         rd_gnt_cyc[2];
    int         stim_timeouts = 0;
    bit         done = 1'b0;
    int         n_checks = 0;
    int         n_fail = 0;
    logic [8:0] last_rd = 9'h000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge CLK) begin
        gnt_exp_t ge;
        rv_exp_t  re;
        if (cyc > 0) begin
            if (reset_q) begin
                check("reset_gnt", {30'd0, gnt}, 32'd0);
                check("reset_rvalid", {30'd0, rvalid}, 32'd0);
                check("reset_rdata", {23'd0, rdata}, 32'd0);
                check("reset_mem_en", {31'd0, mem_en}, 32'd0);
                check("reset_mem_we", {31'd0, mem_we}, 32'd0);
                check("reset_mem_addr", {16'd0, mem_addr}, 32'd0);
                check("reset_mem_wdata", {23'd0, mem_wdata}, 32'd0);
                last_rd = 9'h000;
            end else begin
                if (gnt != 2'b00) begin
                    if (gq.size() == 0) begin
                        check("unexpected_gnt", {30'd0, gnt}, 32'd0);
                    end else begin
                        ge = gq.pop_front();
                        $display("txn gnt[%0d] cycle=%0d mem_en=%0b mem_we=%0b addr=%0d wdata=%03h",
                                 ge.id, cyc, mem_en, mem_we, mem_addr, mem_wdata);
                        check("gnt_id", {30'd0, gnt}, 32'd1 << ge.id);
                        check("mem_en", {31'd0, mem_en}, {31'd0, ge.en});
                        check("mem_we", {31'd0, mem_we}, {31'd0, ge.en & ge.wr});
                        if (ge.en) check("mem_addr", {16'd0, mem_addr}, {16'd0, ge.addr});
                        if (ge.en && ge.wr) check("mem_wdata", {23'd0, mem_wdata}, {23'd0, ge.wdata});
                        if (ge.lat) check("gnt_latency", cyc, req_cycle[ge.id] + 1);
                        if (!ge.wr) rd_gnt_cyc[ge.id] = cyc;
                    end
                end else begin
                    check("idle_mem_en", {31'd0, mem_en}, 32'd0);
                end
                if (rvalid != 2'b00) begin
                    if (rq.size() == 0) begin
                        check("unexpected_rvalid", {30'd0, rvalid}, 32'd0);
                    end else begin
                        re = rq.pop_front();
                        $display("txn rvalid[%0d] cycle=%0d rdata=%03h", re.id, cyc, rdata);
                        check("rvalid_id", {30'd0, rvalid}, 32'd1 << re.id);
                        check("rdata", {23'd0, rdata}, {23'd0, re.data});
                        check("rvalid_latency", cyc, rd_gnt_cyc[re.id] + 1);
                        last_rd = re.data;
                    end
                end else begin
                    check("rdata_hold", {23'd0, rdata}, {23'd0, last_rd});
                end
            end
        end
        if (done) begin
            check("gnt_queue_drained", gq.size(), 32'd0);
            check("rvalid_queue_drained", rq.size(), 32'd0);
            check("stim_timeouts", stim_timeouts, 32'd0);
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $finish;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic push_exp(input int id, input logic w, input logic en, input logic lat,
                            input logic [15:0] addr, input logic [8:0] wd,
                            input logic [8:0] rd, input logic want_rv);
        gnt_exp_t g;
        rv_exp_t  r;
        g.id = 1'(id); g.en = en; g.wr = w; g.lat = lat; g.addr = addr; g.wdata = wd;
        gq.push_back(g);
        if (want_rv) begin
            r.id = 1'(id); r.data = rd;
            rq.push_back(r);
        end
    endtask

    task automatic wait_gnt(input int id);
        int t;
        for (t = 0; t < 20; t++) begin
            @(posedge CLK); #1;
            if (gnt[id]) break;
        end
        if (t == 20) begin
            stim_timeouts++;
            $display("FAIL gnt_timeout: requester %0d got no gnt within 20 cycles", id);
        end
    endtask

    // Single request from one requester, held until its gnt pulse
    task automatic access(input int id, input logic w, input logic [7:0] r, input logic [7:0] c,
                          input logic [8:0] wd, input logic en, input logic [15:0] addr,
                          input logic [8:0] rd);
        push_exp(id, w, en, 1'b1, addr, wd, rd, !w);
        we[id] = w; row[id] = r; col[id] = c; wdata[id] = wd;
        req_cycle[id] = cyc;
        req[id] = 1'b1;
        wait_gnt(id);
        req[id] = 1'b0;
        idle(2);
    endtask

    // Both requesters read fixed cells: 0 -> (1,1) addr 0, 1 -> (3,4) addr 11
    task automatic rr_setup();
        we = 2'b00;
        row[0] = 8'd1; col[0] = 8'd1;
        row[1] = 8'd3; col[1] = 8'd4;
    endtask

    task automatic exp_rr(input int id);
        if (id == 0) push_exp(0, 1'b0, 1'b1, 1'b0, 16'd0, 9'h000, 9'h03C, 1'b1);
        else         push_exp(1, 1'b0, 1'b1, 1'b0, 16'd11, 9'h000, 9'h037, 1'b1);
    endtask

    task automatic burst(input int n);
        int k;
        k = 0;
        req = 2'b11;
        for (int t = 0; t < 4 * n + 10; t++) begin
            @(posedge CLK); #1;
            if (gnt != 2'b00) k++;
            if (k == n) break;
        end
        if (k < n) begin
            stim_timeouts++;
            $display("FAIL burst_timeout: saw %0d of %0d grants", k, n);
        end
        req = 2'b00;
        idle(3);
    endtask

    initial begin
        repeat (3) @(posedge CLK);
        #1 reset = 1'b0;
        idle(2);

        // Single in-frame read: (2,3) in a 4-wide frame -> index 6
        access(0, 1'b0, 8'd2, 8'd3, 9'h000, 1'b1, 16'd6, 9'h03A);

        // Out-of-frame reads: row 0, then row 4 with height 3
        access(1, 1'b0, 8'd0, 8'd1, 9'h000, 1'b0, 16'd0, 9'h100);
        access(1, 1'b0, 8'd4, 8'd1, 9'h000, 1'b0, 16'd0, 9'h100);

        // Round robin, no lock: pointer favours 0
        rr_setup();
        exp_rr(0); exp_rr(1); exp_rr(0); exp_rr(1);
        burst(4);

        // Lock on requester 0: a solo grant keeps 0 on top for the next tie
        lock = 2'b01;
        access(0, 1'b0, 8'd1, 8'd1, 9'h000, 1'b1, 16'd0, 9'h03C);
        rr_setup();
        exp_rr(0); exp_rr(1); exp_rr(0); exp_rr(1);
        burst(4);

        // Lock dropped: a solo grant to 0 now hands the next tie to 1
        lock = 2'b00;
        access(0, 1'b0, 8'd1, 8'd1, 9'h000, 1'b1, 16'd0, 9'h03C);
        rr_setup();
        exp_rr(1); exp_rr(0);
        burst(2);

        // Writes: (3,4) -> index 11; (3,5) is outside a 4-wide frame and is dropped
        access(1, 1'b1, 8'd3, 8'd4, 9'h05A, 1'b1, 16'd11, 9'h000);
        access(1, 1'b1, 8'd3, 8'd5, 9'h05A, 1'b0, 16'd0, 9'h000);

        // Zero width: everything is out of frame
        width = 8'd0;
        access(0, 1'b0, 8'd1, 8'd1, 9'h000, 1'b0, 16'd0, 9'h100);
        width = 8'd4;
        idle(1);

        // Reset while a read is on the memory bus: its rvalid must never appear
        push_exp(0, 1'b0, 1'b1, 1'b1, 16'd6, 9'h000, 9'h000, 1'b0);
        we[0] = 1'b0; row[0] = 8'd2; col[0] = 8'd3;
        req_cycle[0] = cyc;
        req[0] = 1'b1;
        wait_gnt(0);
        req[0] = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge CLK);
        #1 reset = 1'b0;
        idle(2);

        // First tie after reset goes to requester 0
        rr_setup();
        exp_rr(0); exp_rr(1);
        burst(2);

        idle(3);
        done = 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish by %0t", $time);
        $fatal(1);
    end

endmodule
